cmp_sched: RTL and testbench

CMP_SCHED -- requirements
Module: cmp_sched

---
 rtl/cmp_sched_pkg.sv | 44 ++++
 rtl/cmp_sched_rr_arb.sv | 27 ++
 rtl/cmp_sched.sv | 213 +++++++++++++++++++++
 tb/tb_cmp_sched.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sched_pkg.sv
// ---------------------------------------------------------------------------
// cmp_sched_pkg
// Shared types and helpers for the compare scheduler:
//   cond_e     - two-bit condition code carried with each request
//   state_e    - scheduler FSM state encoding (also exported for debug)
//   cond_eval  - reduces subtracting-ALU flags (z, v, n) to a 0/1 result
// ---------------------------------------------------------------------------
package cmp_sched_pkg;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        COND_EQ    = 2'b00,
        COND_LT    = 2'b01,
        COND_LE    = 2'b10,
        COND_NEVER = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Flags come from a - b. Signed less-than is n ^ v, which also covers the
    // case where the subtraction overflowed.
    function automatic logic cond_eval(input cond_e cond, input logic z,
                                       input logic v, input logic n);
        logic lt;
        logic res;
        lt  = n ^ v;
        res = 1'b0;
        case (cond)
            COND_EQ:    res = z;
            COND_LT:    res = lt;
            COND_LE:    res = z | lt;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// cmp_rr_arb2
// Two-way round-robin arbiter. Pure combinational: the caller owns the
// "last grant" register and decides when it advances.
// Ports:
//   valid_i [1:0]  request vector
//   last_i         id of the requester granted most recently
//   grant_o [1:0]  one-hot grant (all zero when nothing is valid)
// ---------------------------------------------------------------------------
module cmp_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/cmp_sched.sv
// ---------------------------------------------------------------------------
// cmp_sched
// Schedules compare requests from two requesters onto one shared subtracting
// ALU. One operation is in flight at a time:
//   IDLE  -> grant a requester (round-robin), latch its operands/condition
//   ISSUE -> one-cycle alu_start pulse
//   WAIT  -> wait for alu_done, or give up after TIMEOUT cycles
//   RESP  -> present the 0/1 result to the granted requester until accepted
// flush returns to IDLE from any state without producing a response.
//
// Handshakes: a request transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; a response transfers in a cycle where
// rsp_valid[i] and rsp_ready[i] are both high. rsp_valid, rsp_result and
// rsp_err stay stable until that transfer.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake [1:0]
//   req_a, req_b          per-requester 32-bit operands
//   req_cond              per-requester condition code
//   flush                 abort the in-flight operation
//   alu_a, alu_b          operands to the ALU (held through ISSUE and WAIT)
//   alu_start             one-cycle launch pulse
//   alu_done, alu_z/v/n   ALU completion strobe and flags
//   rsp_valid/rsp_ready   per-requester response handshake [1:0]
//   rsp_result            compare result, zero-extended 0/1
//   rsp_err               result was produced by timeout
//   busy                  state is not IDLE
//   state_dbg             current FSM state, for observation only
// ---------------------------------------------------------------------------
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][DATA_W-1:0]  req_a,
    input  logic [1:0][DATA_W-1:0]  req_b,
    input  logic [1:0][1:0]         req_cond,
    input  logic                    flush,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic                    alu_start,
    input  logic                    alu_done,
    input  logic                    alu_z,
    input  logic                    alu_v,
    input  logic                    alu_n,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    cond_e              cond_q, cond_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               result_q, result_d;
    logic               err_q, err_d;

    logic [1:0]         grant;
    logic               grant_id;
    logic               accept;
    logic               rsp_fire;
    logic               timed_out;

    cmp_rr_arb2 u_arb (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign grant_id  = grant[1];
    assign accept    = (state_q == ST_IDLE) && !flush && (req_valid != 2'b00);
    assign rsp_fire  = (state_q == ST_RESP) && rsp_ready[id_q];
    assign timed_out = (cnt_q == CNT_TERM);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            // alu_done wins over the terminal count: a late-but-valid
            // completion is reported as a normal result.
            ST_WAIT:  if (alu_done || timed_out) state_d = ST_RESP;
            ST_RESP:  if (rsp_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        alu_start = 1'b0;
        rsp_valid = 2'b00;
        case (state_q)
            // reset_n gating keeps req_ready quiet while reset is asserted.
            ST_IDLE:  if (!flush && reset_n) req_ready = grant;
            ST_ISSUE: alu_start = 1'b1;
            ST_RESP:  rsp_valid[id_q] = 1'b1;
            default:  ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = {{(DATA_W-1){1'b0}}, result_q};
    assign rsp_err    = err_q;

    // -----------------------------------------------------------------------
    // Datapath: latched request, timeout counter, result, last grant
    // -----------------------------------------------------------------------
    always_comb begin
        id_d     = id_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        cond_d   = cond_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d   = grant_id;
                    a_d    = req_a[grant_id];
                    b_d    = req_b[grant_id];
                    cond_d = cond_e'(req_cond[grant_id]);
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                if (!flush) begin
                    if (alu_done) begin
                        result_d = cond_eval(cond_q, alu_z, alu_v, alu_n);
                        err_d    = 1'b0;
                    end else if (timed_out) begin
                        result_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                // A flushed response never completes, so fairness state
                // only advances on a real handshake.
                if (rsp_fire && !flush) begin
                    last_d = id_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_q     <= 1'b0;
            last_q   <= 1'b1;   // requester 0 wins the first tie
            a_q      <= '0;
            b_q      <= '0;
            cond_q   <= COND_EQ;
            cnt_q    <= '0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            id_q     <= id_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cond_q   <= cond_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_cmp_sched.sv
module tb_cmp_sched;
    import cmp_sched_pkg::*;

    localparam int SB_W = 34;   // {id, err, result[31:0]}

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic [1:0][1:0]  req_cond = '0;
    logic             flush = 1'b0;
    logic [31:0]      alu_a, alu_b;
    logic             alu_start;
    logic             alu_done = 1'b0;
    logic             alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b11;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic             busy;
    logic [1:0]       state_dbg;

    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               alu_delay = 1;
    bit               alu_mute = 1'b0;
    logic [SB_W-1:0]  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_sched #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cond   (req_cond),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_n      (alu_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Reference compare, written directly on signed operands.
    function automatic logic ref_cmp(input logic [1:0] c, input logic [31:0] a,
                                     input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (c)
            2'b00: r = (a == b);
            2'b01: r = ($signed(a) < $signed(b));
            2'b10: r = ($signed(a) <= $signed(b));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ALU model: real subtraction flags, done after alu_delay cycles.
    initial begin : alu_model
        logic [31:0] a, b, d;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1 && !alu_mute) begin
                a = alu_a;
                b = alu_b;
                d = a - b;
                repeat (alu_delay) @(posedge clk);
                #1;
                alu_done = 1'b1;
                alu_z    = (d == 32'h0);
                alu_n    = d[31];
                alu_v    = (a[31] != b[31]) && (d[31] != a[31]);
                @(posedge clk);
                #1;
                alu_done = 1'b0;
                alu_z    = 1'b0;
                alu_n    = 1'b0;
                alu_v    = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for its accept, optionally records the
    // expected response. Returns in the cycle after acceptance (ISSUE).
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input bit push, input bit exp_err,
                        output int t_acc);
        bit got;
        got = 1'b0;
        t_acc = -1;
        req_a[id]     = a;
        req_b[id]     = b;
        req_cond[id]  = c;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: req%0d not accepted, req_ready=%b", id, req_ready);
            req_valid[id] = 1'b0;
        end else begin
            t_acc = cyc;
            if (push)
                exp_q.push_back(exp_err ? {1'(id), 1'b1, 32'h0}
                                        : {1'(id), 1'b0, 31'h0, ref_cmp(c, a, b)});
            tick();
            req_valid[id] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, expected idle with 0 pending",
                     busy, exp_q.size());
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_checks++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL reset_alu_start: got %b expected 0", alu_start); end
        n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
        n_checks++; if (alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 0", alu_b); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        int grants;
        int gid;
        logic [31:0] v;
        grants = 0;
        for (int r = 0; r < 2; r++) begin
            v = $urandom;
            req_a[r] = v; req_b[r] = v; req_cond[r] = COND_EQ;
        end
        req_valid = 2'b11;
        for (int i = 0; i < 200 && grants < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gid = req_ready[1] ? 1 : 0;
                n_checks++;
                if (req_ready !== (grants % 2 == 0 ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d: got req_ready=%b expected %b",
                             grants, req_ready, (grants % 2 == 0 ? 2'b01 : 2'b10));
                end
                exp_q.push_back({1'(gid), 1'b0, 31'h0, ref_cmp(req_cond[gid], req_a[gid], req_b[gid])});
                grants++;
                tick();
                v = $urandom;
                req_a[gid] = v; req_b[gid] = v;
                if (grants == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        n_checks++;
        if (grants != 4) begin n_fail++; $display("FAIL contention_count: got %0d grants expected 4", grants); end
        wait_idle();
    endtask

    task automatic test_single();
        int t;
        alu_delay = 1;
        send(0, 32'd5, 32'd7, COND_LT, 1'b1, 1'b0, t);
        @(negedge clk);   // T+1
        n_checks++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL single_alu_start: got %b expected 1", alu_start); end
        n_checks++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL single_alu_a: got %0d expected 5", alu_a); end
        n_checks++; if (alu_b !== 32'd7) begin n_fail++; $display("FAIL single_alu_b: got %0d expected 7", alu_b); end
        @(negedge clk);   // T+2
        n_checks++; if (rsp_valid !== 2'b00 || alu_start !== 1'b0) begin n_fail++; $display("FAIL single_t2: got rsp_valid=%b alu_start=%b expected 00/0", rsp_valid, alu_start); end
        n_checks++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL single_hold_a: got %0d expected 5", alu_a); end
        @(negedge clk);   // T+3
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_t3_valid: got %b expected 01", rsp_valid); end
        wait_idle();
    endtask

    task automatic test_random();
        int t, id;
        logic [31:0] a, b;
        for (int k = 0; k < 6; k++) begin
            id = $urandom_range(0, 1);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            alu_delay = $urandom_range(1, 4);
            send(id, a, b, 2'($urandom_range(0, 3)), 1'b1, 1'b0, t);
            wait_idle();
        end
        alu_delay = 1;
    endtask

    task automatic test_timeout();
        int t, seen;
        // No done at all: 16 WAIT cycles then an error response.
        alu_mute = 1'b1;
        send(1, 32'd1, 32'd1, COND_EQ, 1'b1, 1'b1, t);
        @(negedge clk);
        n_checks++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b expected 1", alu_start); end
        seen = -1;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = cyc;
        end
        n_checks++; if (seen != t + 18) begin n_fail++; $display("FAIL timeout_latency: got rsp at +%0d expected +18", seen - t); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_result !== 32'h0) begin n_fail++; $display("FAIL timeout_value: got err=%b result=%h expected 1/0", rsp_err, rsp_result); end
        wait_idle();
        alu_mute = 1'b0;
        // done on the terminal count is a normal completion.
        alu_delay = 16;
        send(0, 32'd4, 32'd4, COND_EQ, 1'b1, 1'b0, t);
        seen = -1;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = cyc;
        end
        n_checks++; if (seen != t + 18) begin n_fail++; $display("FAIL terminal_done_latency: got rsp at +%0d expected +18", seen - t); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL terminal_done_err: got %b expected 0", rsp_err); end
        wait_idle();
        alu_delay = 1;
    endtask

    task automatic test_backpressure();
        int t;
        bit seen;
        rsp_ready = 2'b10;   // only the non-granted side is ready
        send(0, 32'd3, 32'd3, COND_LE, 1'b1, 1'b0, t);
        req_a[1] = 32'd2; req_b[1] = 32'd9; req_cond[1] = COND_LT;
        req_valid[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_no_rsp: got rsp_valid=%b expected 01", rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'h1 || rsp_err !== 1'b0 ||
                req_ready !== 2'b00 || alu_start !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b result=%h err=%b req_ready=%b start=%b expected 01/1/0/00/0",
                         k, rsp_valid, rsp_result, rsp_err, req_ready, alu_start);
            end
        end
        tick();
        rsp_ready = 2'b11;
        send(1, 32'd2, 32'd9, COND_LT, 1'b1, 1'b0, t);
        wait_idle();
    endtask

    task automatic test_flush();
        int t;
        alu_delay = 2;
        send(0, 32'd10, 32'd20, COND_LT, 1'b0, 1'b0, t);
        tick();             // first WAIT cycle
        flush = 1'b1;
        tick();             // ALU done arrives this cycle
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL flush_idle: got busy=%b state=%0d expected 0/IDLE", busy, state_dbg); end
        n_checks++; if (alu_done !== 1'b1) begin n_fail++; $display("FAIL flush_stale_done: got alu_done=%b expected 1", alu_done); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got rsp_valid=%b busy=%b expected 00/0", k, rsp_valid, busy); end
            @(negedge clk);
        end
        // flush in IDLE holds off acceptance.
        tick();
        alu_delay = 1;
        flush = 1'b1;
        req_a[0] = 32'hFFFF_FFF0; req_b[0] = 32'd3; req_cond[0] = COND_LT;
        req_valid[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_idle_block: got req_ready=%b expected 00", req_ready); end
        tick();
        flush = 1'b0;
        send(0, 32'hFFFF_FFF0, 32'd3, COND_LT, 1'b1, 1'b0, t);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int t;
        bit got;
        // Make requester 0 the last grant, so only reset can restore its tie priority.
        send(0, 32'd1, 32'd2, COND_LT, 1'b1, 1'b0, t);
        wait_idle();
        alu_delay = 3;
        send(0, 32'd5, 32'd5, COND_EQ, 1'b0, 1'b0, t);
        tick();             // first WAIT cycle
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        alu_delay = 1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00 || alu_start !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 ||
            rsp_valid !== 2'b00 || rsp_result !== 32'h0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b start=%b a=%h b=%h valid=%b result=%h err=%b busy=%b expected all 0",
                     req_ready, alu_start, alu_a, alu_b, rsp_valid, rsp_result, rsp_err, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midreset_stale%0d: got busy=%b rsp_valid=%b expected 0/00", k, busy, rsp_valid); end
        end
        tick();
        for (int r = 0; r < 2; r++) begin
            req_a[r] = 32'd9; req_b[r] = 32'd9; req_cond[r] = COND_NEVER;
        end
        req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midreset_tie: got req_ready=%b expected 01", req_ready); end
        if (got) exp_q.push_back({1'(req_ready[1]), 1'b0, 32'h0});
        tick();
        req_valid[0] = 1'b0;
        send(1, 32'd9, 32'd9, COND_NEVER, 1'b1, 1'b0, t);
        wait_idle();
    endtask

    // ------------------------------------------------------------------
    // Sequencer, scoreboard and report
    // ------------------------------------------------------------------
    initial begin
        fork
            begin : scoreboard
                logic [SB_W-1:0] e;
                logic [1:0] ev;
                forever begin
                    @(negedge clk);
                    if (reset_n === 1'b1 && (rsp_valid & rsp_ready) != 2'b00) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rsp_unexpected: got rsp_valid=%b result=%h, expected no response",
                                     rsp_valid, rsp_result);
                        end else begin
                            e  = exp_q.pop_front();
                            ev = e[33] ? 2'b10 : 2'b01;
                            if (rsp_valid !== ev || rsp_err !== e[32] || rsp_result !== e[31:0]) begin
                                n_fail++;
                                $display("FAIL rsp_scoreboard: got valid=%b err=%b result=%h, expected valid=%b err=%b result=%h",
                                         rsp_valid, rsp_err, rsp_result, ev, e[32], e[31:0]);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_contention();
        test_single();
        test_random();
        test_timeout();
        test_backpressure();
        test_flush();
        test_reset_mid();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
